// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and mode validation for the serial ALU sequencer.
package alu_pkg;

    localparam logic [2:0] ADD  = 3'b000;
    localparam logic [2:0] AND  = 3'b001;
    localparam logic [2:0] OR   = 3'b010;
    localparam logic [2:0] XOR  = 3'b011;
    localparam logic [2:0] XNOR = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    function automatic logic is_valid_mode(input logic [2:0] mode);
        return mode <= XNOR;
    endfunction

endpackage

// File: rtl/alu_shift_piso.sv
// Parallel-load, LSB-first shift register feeding one operand bit per cycle.
module alu_shift_piso #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             bit_out
);

    logic [WIDTH-1:0] shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= data;
        end else if (shift) begin
            shreg <= {1'b0, shreg[WIDTH-1:1]};
        end
    end

    assign bit_out = shreg[0];

endmodule

// File: rtl/alu_serial_sequencer.sv
// Bit-serial sequencer driving an external 1-bit ALU over WIDTH cycles, LSB first,
// assembling the result word and final carry.
module alu_serial_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             Start,
    input  logic [2:0]       Mode,
    input  logic [WIDTH-1:0] Op_A,
    input  logic [WIDTH-1:0] Op_B,
    output logic [2:0]       Alu_Mode,
    output logic             Alu_A,
    output logic             Alu_B,
    output logic             Alu_C_in,
    input  logic             Alu_X,
    input  logic             Alu_C_out,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Carry,
    output logic             Err
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             running;
    logic [2:0]       mode_q;
    logic [IDX_W-1:0] idx;
    logic             carry_q;
    logic             a_bit;
    logic             b_bit;

    assign accept  = (state == IDLE) && Start;
    assign running = (state == RUN);

    alu_shift_piso #(.WIDTH(WIDTH)) u_shift_a (
        .clk     (CLK),
        .rst_n   (RST_N),
        .load    (accept),
        .shift   (running),
        .data    (Op_A),
        .bit_out (a_bit)
    );

    alu_shift_piso #(.WIDTH(WIDTH)) u_shift_b (
        .clk     (CLK),
        .rst_n   (RST_N),
        .load    (accept),
        .shift   (running),
        .data    (Op_B),
        .bit_out (b_bit)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (Start) state_nxt = is_valid_mode(Mode) ? RUN : FINISH;
            RUN:     if (idx == LAST_IDX) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ALU-facing signals are forced to zero whenever no bit is being processed.
    always_comb begin
        Busy     = 1'b0;
        Done     = 1'b0;
        Alu_Mode = '0;
        Alu_A    = 1'b0;
        Alu_B    = 1'b0;
        Alu_C_in = 1'b0;
        unique case (state)
            RUN: begin
                Busy     = 1'b1;
                Alu_Mode = mode_q;
                Alu_A    = a_bit;
                Alu_B    = b_bit;
                Alu_C_in = (mode_q == ADD) ? carry_q : 1'b0;
            end
            FINISH:  Done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mode_q  <= '0;
            idx     <= '0;
            carry_q <= 1'b0;
            Result  <= '0;
            Carry   <= 1'b0;
            Err     <= 1'b0;
        end else if (accept) begin
            mode_q  <= Mode;
            idx     <= '0;
            carry_q <= 1'b0;
            Result  <= '0;
            Carry   <= 1'b0;
            Err     <= ~is_valid_mode(Mode);
        end else if (running) begin
            Result[idx] <= Alu_X;
            carry_q     <= Alu_C_out;
            // The index stops at the last bit instead of wrapping.
            if (idx == LAST_IDX) begin
                Carry <= (mode_q == ADD) & Alu_C_out;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: doc/alu_serial_sequencer.md
ALU_SERIAL_SEQUENCER -- requirements
Module: alu_serial_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (2..32).
REQ-002 SHALL have ports, in order:
- CLK  in  1  single clock; all state on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- Start  in  1  request; accepted only in IDLE.
- Mode  in  3  opcode: 000 add, 001 AND, 010 OR, 011 XOR, 100 XNOR; 101-111 invalid.
- Op_A  in  WIDTH  operand A, sampled on accepted Start.
- Op_B  in  WIDTH  operand B, sampled on accepted Start.
- Alu_Mode  out  3  opcode driven to the external 1-bit ALU.
- Alu_A  out  1  current A bit to the ALU.
- Alu_B  out  1  current B bit to the ALU.
- Alu_C_in  out  1  carry-in to the ALU.
- Alu_X  in  1  ALU result bit, combinational from Alu_* outputs.
- Alu_C_out  in  1  ALU carry-out, combinational; nonzero only in add.
- Busy  out  1  high from Start acceptance until Done.
- Done  out  1  one-cycle completion pulse.
- Result  out  WIDTH  assembled result; held until next accepted Start.
- Carry  out  1  final carry (add only, else 0); held like Result.
- Err  out  1  invalid Mode on last operation; held like Result.

Function
REQ-003 SHALL implement FSM states IDLE, RUN, FINISH.
REQ-004 IDLE with Start=1 SHALL latch Mode/Op_A/Op_B, clear bit index and carry register, and raise Busy next cycle.
- Valid Mode: go to RUN.
- Invalid Mode: go to FINISH.
REQ-005 RUN SHALL process one bit per cycle, LSB first, for exactly WIDTH cycles; bit index i drives Alu_A=A[i], Alu_B=B[i].
REQ-006 Alu_C_in SHALL be the carry register in add mode (0 at bit 0, then previous Alu_C_out) and 0 in all other modes.
REQ-007 On each RUN edge SHALL capture Alu_X into Result bit i and Alu_C_out into the carry register.
REQ-008 After bit WIDTH-1, SHALL enter FINISH.
REQ-009 FINISH SHALL last one cycle with Done=1, Busy=0, then return to IDLE.
- Carry = final carry register (0 unless add).
- Err = 1 only for invalid Mode, in which case Result = 0 and Carry = 0.
REQ-010 Latency SHALL be fixed: Done asserted WIDTH+1 cycles after the Start-accepting edge (valid Mode), 1 cycle after it (invalid Mode).
REQ-011 Start while Busy or in FINISH SHALL be ignored with no effect on the current operation; a new Start is accepted only in IDLE.
REQ-012 Alu_Mode SHALL hold the latched Mode during RUN; Alu_A, Alu_B, Alu_C_in SHALL be 0 outside RUN.
REQ-013 Changes on Op_A, Op_B or Mode after acceptance SHALL NOT affect the running operation.
REQ-014 Bit index SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap; termination is by index == WIDTH-1.

Reset
REQ-015 RST_N low SHALL, asynchronously, force:
- state IDLE;
- Busy=0, Done=0, Err=0, Carry=0, Result=0;
- Alu_Mode=000, Alu_A=0, Alu_B=0, Alu_C_in=0;
- carry register and bit index cleared.
REQ-016 Reset mid-operation SHALL abort it with no Done pulse; first Start after release SHALL be accepted normally.

Structure
REQ-017 Shared package alu_pkg SHALL hold the opcode constants (ADD, AND, OR, XOR, XNOR), the state enumeration, and an is_valid_mode function.
REQ-018 One sub-module SHALL be used: alu_shift_piso, a WIDTH-bit parallel-load, LSB-first shift register, instantiated twice for Op_A and Op_B.
REQ-019 The 1-bit ALU SHALL stay external, connected via Alu_* ports; the bench SHALL instantiate it alongside.

Verification
REQ-020 The bench SHALL cover these scenarios (WIDTH=8 unless stated):
- Add: Op_A=0xFF, Op_B=0x01 -> Result=0x00, Carry=1, Err=0, Done exactly 9 cycles after Start edge.
- AND 0xF0,0x3C -> 0x30; OR -> 0xFC; XOR -> 0xCC; XNOR 0xA5,0x0F -> 0x55; Carry=0 in all.
- Invalid Mode=101 -> Done 1 cycle after Start, Err=1, Result=0x00, Alu_A/B/C_in stay 0.
- Start re-asserted during RUN with different operands -> ignored; Result equals the first operation; next Start after Done accepted.
- RST_N pulsed low at bit 4 of an add -> all outputs 0 immediately, no Done; a following add 0x12+0x34 -> 0x46, Carry=0.
- WIDTH=16: 0x8000+0x8000 -> Result=0x0000, Carry=1, Done 17 cycles after Start.
